ikaopm_dac_decoder: RTL and testbench

//  Downstream consumer of the OPM serial sound output (SO). Deserialises the 16-bit floating-point

---
 rtl/ikaopm_dac_decoder.sv | 160 ++++++++++++++++
 tb/tb_ikaopm_dac_decoder.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ikaopm_dac_decoder.sv
// YM3012-style serial DAC decoder: deserialises 16-bit floating-point sound
// words from the OPM SO pin and expands them to signed 16-bit linear samples.
//
// Interface note: there is no backpressure. o_R_VALID / o_L_VALID / o_ERR are
// valid-only strobes. Each one is high for exactly one enabled period and
// drops on the next enabled edge. A consumer must sample on that enabled edge.
module ikaopm_dac_decoder #(
    parameter bit SYNC_CHECK = 1'b1,
    parameter bit MUTE_EXP0  = 1'b1
) (
    input  logic        i_EMUCLK,
    input  logic        i_MRST,
    input  logic        i_phi1_NCEN_n,
    input  logic        i_SO,
    input  logic        i_SYNC,
    input  logic        i_LR,
    output logic [15:0] o_R,
    output logic [15:0] o_L,
    output logic        o_R_VALID,
    output logic        o_L_VALID,
    output logic        o_ERR,
    output logic [1:0]  o_DBG_STATE
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        RECV   = 2'd1,
        DECODE = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic        en;
    logic [15:0] sr;
    logic [3:0]  cnt;
    logic        ch;

    // Control decisions for the current enabled edge.
    logic        start_word;
    logic        shift_bit;
    logic        err_pulse;
    logic        dec_pulse;

    // Decoded fields of a complete word held in the shift register.
    logic [8:0]         mant;
    logic               sgn;
    logic [2:0]         expo;
    logic signed [15:0] lin;
    logic signed [15:0] sample;

    assign en          = ~i_phi1_NCEN_n;
    assign o_DBG_STATE = state;

    // State register; reset wins over the bit clock enable.
    always_ff @(posedge i_EMUCLK) begin
        if (i_MRST) begin
            state <= HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and per-edge control strobes.
    always_comb begin
        state_nxt  = state;
        start_word = 1'b0;
        shift_bit  = 1'b0;
        err_pulse  = 1'b0;
        dec_pulse  = 1'b0;
        if (en) begin
            case (state)
                HUNT: begin
                    if (i_SYNC) begin
                        start_word = 1'b1;
                        state_nxt  = RECV;
                    end
                end
                RECV: begin
                    // In RECV the counter is always past bit 0, so a sync here
                    // always interrupts a partial word.
                    if (i_SYNC) begin
                        start_word = 1'b1;
                        err_pulse  = SYNC_CHECK;
                    end else begin
                        shift_bit = 1'b1;
                        if (cnt == 4'd15) begin
                            state_nxt = DECODE;
                        end
                    end
                end
                DECODE: begin
                    // Publish the finished word; a sync here is a legal
                    // back-to-back start and carries bit 0 of the next word.
                    dec_pulse = 1'b1;
                    if (i_SYNC) begin
                        start_word = 1'b1;
                        state_nxt  = RECV;
                    end else begin
                        state_nxt = HUNT;
                    end
                end
                default: begin
                    state_nxt = HUNT;
                end
            endcase
        end
    end

    // Field extraction and floating-point to linear expansion.
    always_comb begin
        mant   = sr[11:3];
        sgn    = sr[12];
        expo   = sr[15:13];
        // Offset binary: S = 1 means non-negative, so the sign bit is ~S.
        lin    = {{6{~sgn}}, ~sgn, mant};
        sample = '0;
        if (expo == 3'd0) begin
            sample = MUTE_EXP0 ? 16'sd0 : lin;
        end else begin
            sample = lin <<< (expo - 3'd1);
        end
    end

    // Datapath: shift register, bit counter, channel flag, outputs, strobes.
    always_ff @(posedge i_EMUCLK) begin
        if (i_MRST) begin
            sr        <= '0;
            cnt       <= '0;
            ch        <= 1'b0;
            o_R       <= '0;
            o_L       <= '0;
            o_R_VALID <= 1'b0;
            o_L_VALID <= 1'b0;
            o_ERR     <= 1'b0;
        end else if (en) begin
            o_R_VALID <= 1'b0;
            o_L_VALID <= 1'b0;
            o_ERR     <= err_pulse;
            if (start_word) begin
                sr  <= {i_SO, 15'd0};
                cnt <= 4'd1;
                ch  <= i_LR;
            end else if (shift_bit) begin
                // LSB first: after 16 shifts bit k sits at sr[k]; cnt wraps to 0.
                sr  <= {i_SO, sr[15:1]};
                cnt <= cnt + 4'd1;
            end
            // The decode reads the pre-edge sr/ch, so a simultaneous start is safe.
            if (dec_pulse) begin
                if (ch) begin
                    o_L       <= sample;
                    o_L_VALID <= 1'b1;
                end else begin
                    o_R       <= sample;
                    o_R_VALID <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ikaopm_dac_decoder.sv
// Bench for ikaopm_dac_decoder: directed vectors plus a long random
// back-to-back stream checked against a word-level reference model.
module tb_ikaopm_dac_decoder;

    localparam bit SYNC_CHECK = 1'b1;
    localparam bit MUTE_EXP0  = 1'b1;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        mrst = 1'b1;
    logic        ncen = 1'b1;
    logic        so_in = 1'b0;
    logic        sync_in = 1'b0;
    logic        lr_in = 1'b0;
    logic [15:0] o_r, o_l;
    logic        r_valid, l_valid, err;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    ikaopm_dac_decoder #(
        .SYNC_CHECK(SYNC_CHECK),
        .MUTE_EXP0 (MUTE_EXP0)
    ) dut (
        .i_EMUCLK     (clk),
        .i_MRST       (mrst),
        .i_phi1_NCEN_n(ncen),
        .i_SO         (so_in),
        .i_SYNC       (sync_in),
        .i_LR         (lr_in),
        .o_R          (o_r),
        .o_L          (o_l),
        .o_R_VALID    (r_valid),
        .o_L_VALID    (l_valid),
        .o_ERR        (err),
        .o_DBG_STATE  (dbg_state)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    logic [15:0] m_r, m_l;
    logic        e_rv, e_lv, e_err;
    logic        m_active, m_ready, m_ch, m_wch;
    logic [15:0] m_word;
    logic        m_bits[$];

    function automatic logic [15:0] ref_decode(input logic [15:0] w);
        int mant, s, e, v;
        mant = int'(w[11:3]);
        s    = int'(w[12]);
        e    = int'(w[15:13]);
        v    = (s == 1) ? mant : mant - 512;
        if (e == 0) begin
            if (MUTE_EXP0) return 16'd0;
            e = 1;
        end
        return 16'(v * (1 << (e - 1)));
    endfunction

    function automatic logic [15:0] mk_word(input logic s, input logic [8:0] mant,
                                            input logic [2:0] e);
        logic [2:0] dummy;
        dummy = 3'($urandom);
        return {e, s, mant, dummy};
    endfunction

    task automatic model_reset();
        m_r = '0; m_l = '0;
        e_rv = 0; e_lv = 0; e_err = 0;
        m_active = 0; m_ready = 0; m_ch = 0; m_wch = 0; m_word = '0;
        m_bits.delete();
    endtask

    // One enabled bit period as seen by the model.
    task automatic model_step(input logic so, input logic sync, input logic lr);
        e_rv = 0; e_lv = 0; e_err = 0;
        if (m_ready) begin
            if (m_wch) begin m_l = ref_decode(m_word); e_lv = 1; end
            else       begin m_r = ref_decode(m_word); e_rv = 1; end
            m_ready = 0;
        end
        if (sync) begin
            if (m_bits.size() != 0) e_err = SYNC_CHECK;
            m_bits.delete();
            m_bits.push_back(so);
            m_ch = lr;
            m_active = 1;
        end else if (m_active) begin
            m_bits.push_back(so);
            if (m_bits.size() == 16) begin
                for (int k = 0; k < 16; k++) m_word[k] = m_bits[k];
                m_wch = m_ch;
                m_ready = 1;
                m_bits.delete();
                m_active = 0;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    // Drive one enabled bit, then 'gap' disabled clocks carrying random junk.
    task automatic drive_bit(input logic so, input logic sync, input logic lr, input int gap);
        so_in = so; sync_in = sync; lr_in = lr; ncen = 1'b0;
        @(posedge clk);
        model_step(so, sync, lr);
        #1;
        ncen = 1'b1;
        so_in = 1'($urandom); sync_in = 1'($urandom); lr_in = 1'($urandom);
        if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bits(input logic [15:0] w, input logic lr, input int from, input int upto);
        for (int k = from; k <= upto; k++) drive_bit(w[k], (k == 0), lr, int'($urandom_range(0, 2)));
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        mrst = 1'b1; ncen = 1'b0; sync_in = 1'b1; so_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        mrst = 1'b0; ncen = 1'b1; sync_in = 1'b0;
        model_reset();
        checks += 6;
        if (o_r !== 16'd0) begin errors++; $display("FAIL reset_o_r got %h exp 0000", o_r); end
        if (o_l !== 16'd0) begin errors++; $display("FAIL reset_o_l got %h exp 0000", o_l); end
        if (r_valid !== 1'b0) begin errors++; $display("FAIL reset_rv got %b exp 0", r_valid); end
        if (l_valid !== 1'b0) begin errors++; $display("FAIL reset_lv got %b exp 0", l_valid); end
        if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
        if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
    endtask

    task automatic test_spec_vectors();
        logic [15:0] w1, w2, w3, w4, w5;
        w1 = mk_word(1'b1, 9'h1FF, 3'd7);
        w2 = mk_word(1'b0, 9'h000, 3'd7);
        w3 = mk_word(1'b1, 9'h005, 3'd1);
        w4 = mk_word(1'b0, 9'h1FE, 3'd3);
        w5 = mk_word(1'b1, 9'h123, 3'd0);
        send_bits(w1, 1'b0, 0, 15);
        drive_bit(w2[0], 1'b1, 1'b1, 1);
        checks += 4;
        if (o_r !== 16'h7FC0) begin errors++; $display("FAIL vec_r_max got %h exp 7fc0", o_r); end
        if (r_valid !== 1'b1) begin errors++; $display("FAIL vec_r_max_rv got %b exp 1", r_valid); end
        if (l_valid !== 1'b0) begin errors++; $display("FAIL vec_r_max_lv got %b exp 0", l_valid); end
        if (o_l !== 16'h0000) begin errors++; $display("FAIL vec_l_hold got %h exp 0000", o_l); end
        drive_bit(w2[1], 1'b0, 1'b0, 0);
        checks += 1;
        if (r_valid !== 1'b0) begin errors++; $display("FAIL vec_rv_one_period got %b exp 0", r_valid); end
        send_bits(w2, 1'b1, 2, 15);
        drive_bit(w3[0], 1'b1, 1'b1, 1);
        checks += 3;
        if (o_l !== 16'h8000) begin errors++; $display("FAIL vec_l_min got %h exp 8000", o_l); end
        if (l_valid !== 1'b1) begin errors++; $display("FAIL vec_l_min_lv got %b exp 1", l_valid); end
        if (o_r !== 16'h7FC0) begin errors++; $display("FAIL vec_r_hold got %h exp 7fc0", o_r); end
        send_bits(w3, 1'b1, 1, 15);
        drive_bit(w4[0], 1'b1, 1'b0, 0);
        checks += 1;
        if (o_l !== 16'h0005) begin errors++; $display("FAIL vec_l_exp1 got %h exp 0005", o_l); end
        send_bits(w4, 1'b0, 1, 15);
        drive_bit(w5[0], 1'b1, 1'b0, 2);
        checks += 2;
        if (o_r !== 16'hFFF8) begin errors++; $display("FAIL vec_r_neg2 got %h exp fff8", o_r); end
        if (r_valid !== 1'b1) begin errors++; $display("FAIL vec_r_neg2_rv got %b exp 1", r_valid); end
        send_bits(w5, 1'b0, 1, 15);
        drive_bit(1'b1, 1'b0, 1'b0, 1);
        checks += 2;
        if (o_r !== 16'h0000) begin errors++; $display("FAIL vec_r_exp0 got %h exp 0000", o_r); end
        if (r_valid !== 1'b1) begin errors++; $display("FAIL vec_r_exp0_rv got %b exp 1", r_valid); end
        drive_bit(1'b1, 1'b0, 1'b0, 0);
        checks += 1;
        if (r_valid !== 1'b0) begin errors++; $display("FAIL vec_hunt_rv got %b exp 0", r_valid); end
    endtask

    task automatic test_sync_error();
        logic [15:0] w1, w2;
        w1 = mk_word(1'b1, 9'h0AA, 3'd2);
        w2 = mk_word(1'b0, 9'h100, 3'd4);
        send_bits(w1, 1'b0, 0, 6);
        drive_bit(w2[0], 1'b1, 1'b0, 1);
        checks += 2;
        if (err !== 1'b1) begin errors++; $display("FAIL serr_err got %b exp 1", err); end
        if (r_valid !== 1'b0) begin errors++; $display("FAIL serr_rv got %b exp 0", r_valid); end
        drive_bit(w2[1], 1'b0, 1'b0, 0);
        checks += 1;
        if (err !== 1'b0) begin errors++; $display("FAIL serr_err_drop got %b exp 0", err); end
        send_bits(w2, 1'b0, 2, 15);
        drive_bit(1'b0, 1'b0, 1'b0, 1);
        checks += 3;
        if (o_r !== 16'hF800) begin errors++; $display("FAIL serr_next_word got %h exp f800", o_r); end
        if (r_valid !== 1'b1) begin errors++; $display("FAIL serr_next_rv got %b exp 1", r_valid); end
        if (err !== 1'b0) begin errors++; $display("FAIL serr_next_err got %b exp 0", err); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] w;
        int bad;
        w = mk_word(1'b1, 9'h055, 3'd5);
        send_bits(w, 1'b1, 0, 8);
        so_in = w[9]; sync_in = 1'b0; ncen = 1'b0; mrst = 1'b1;
        @(posedge clk);
        #1;
        mrst = 1'b0; ncen = 1'b1;
        model_reset();
        checks += 5;
        if (o_r !== 16'd0) begin errors++; $display("FAIL rmid_o_r got %h exp 0000", o_r); end
        if (o_l !== 16'd0) begin errors++; $display("FAIL rmid_o_l got %h exp 0000", o_l); end
        if (r_valid !== 1'b0 || l_valid !== 1'b0) begin
            errors++; $display("FAIL rmid_strobes got %b%b exp 00", r_valid, l_valid);
        end
        if (err !== 1'b0) begin errors++; $display("FAIL rmid_err got %b exp 0", err); end
        if (dbg_state !== 2'd0) begin errors++; $display("FAIL rmid_state got %0d exp 0", dbg_state); end
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            drive_bit(1'($urandom), 1'b0, 1'($urandom), 1);
            if (r_valid !== 1'b0 || l_valid !== 1'b0 || err !== 1'b0 || o_r !== 16'd0 || o_l !== 16'd0) bad++;
        end
        checks += 1;
        if (bad != 0) begin errors++; $display("FAIL hunt_ignores_data got %0d bad periods exp 0", bad); end
        send_bits(w, 1'b1, 0, 15);
        drive_bit(1'b0, 1'b0, 1'b0, 1);
        checks += 3;
        if (o_l !== 16'h0550) begin errors++; $display("FAIL rmid_first_word got %h exp 0550", o_l); end
        if (l_valid !== 1'b1) begin errors++; $display("FAIL rmid_first_lv got %b exp 1", l_valid); end
        if (o_r !== 16'h0000) begin errors++; $display("FAIL rmid_r_hold got %h exp 0000", o_r); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] w;
        logic        lr;
        int          n_rv, n_lv;
        n_rv = 0; n_lv = 0;
        for (int i = 0; i < 1000; i++) begin
            w  = 16'($urandom);
            lr = i[0];
            for (int k = 0; k < 16; k++) begin
                drive_bit(w[k], (k == 0), lr, 1);
                if (r_valid === 1'b1) n_rv++;
                if (l_valid === 1'b1) n_lv++;
                checks += 5;
                if (o_r !== m_r) begin errors++; $display("FAIL b2b_o_r word %0d bit %0d got %h exp %h", i, k, o_r, m_r); end
                if (o_l !== m_l) begin errors++; $display("FAIL b2b_o_l word %0d bit %0d got %h exp %h", i, k, o_l, m_l); end
                if (r_valid !== e_rv) begin errors++; $display("FAIL b2b_rv word %0d bit %0d got %b exp %b", i, k, r_valid, e_rv); end
                if (l_valid !== e_lv) begin errors++; $display("FAIL b2b_lv word %0d bit %0d got %b exp %b", i, k, l_valid, e_lv); end
                if (err !== e_err) begin errors++; $display("FAIL b2b_err word %0d bit %0d got %b exp %b", i, k, err, e_err); end
            end
        end
        drive_bit(1'b0, 1'b0, 1'b0, 1);
        if (l_valid === 1'b1) n_lv++;
        checks += 3;
        if (o_l !== m_l) begin errors++; $display("FAIL b2b_last_word got %h exp %h", o_l, m_l); end
        if (n_rv != 500) begin errors++; $display("FAIL b2b_r_count got %0d exp 500", n_rv); end
        if (n_lv != 500) begin errors++; $display("FAIL b2b_l_count got %0d exp 500", n_lv); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        model_reset();
        test_reset();
        test_spec_vectors();
        test_sync_error();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
